// File: rtl/exe_muldiv_ctrl.sv
// exe_muldiv_ctrl: multi-cycle MULT/MULTU/DIV/DIVU sequencer beside the EXE ALU.
// It owns HI/LO and stalls the front of the pipe only when a dependent instruction
// (another mul/div, MFHI/MFLO, MTHI/MTLO) meets an operation in flight.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   start, op              launch request; op 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   operand_a, operand_b   forwarded rs/rt values
//   hilo_read              EXE holds MFHI/MFLO
//   hi_we, lo_we, wdata    MTHI/MTLO write port
//   flush                  squash the in-flight (or same-cycle) operation
//   busy, stall            operation in flight / freeze IF-ID-EXE
//   done                   one-cycle pulse after HI/LO written by an operation
//   div_zero               sticky: last divide had a zero divisor
//   hi, lo                 HI/LO registers
module exe_muldiv_ctrl #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       op,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             hilo_read,
   input  logic             hi_we,
   input  logic             lo_we,
   input  logic [WIDTH-1:0] wdata,
   input  logic             flush,
   output logic             busy,
   output logic             stall,
   output logic             done,
   output logic             div_zero,
   output logic [WIDTH-1:0] hi,
   output logic [WIDTH-1:0] lo
);

   localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {StIdle, StRun, StFix} state_e;

   state_e             state_q, state_d;
   logic [CW-1:0]      count_q, count_d;
   // Multiply: {partial product, multiplier}. Divide: {remainder, quotient}.
   logic [2*WIDTH-1:0] acc_q, acc_d;
   logic [WIDTH-1:0]   b_q, b_d;
   logic               is_div_q, is_div_d;
   logic               sgn_quo_q, sgn_quo_d;
   logic               sgn_rem_q, sgn_rem_d;
   logic [WIDTH-1:0]   hi_q, hi_d, lo_q, lo_d;
   logic               done_q, done_d;
   logic               dz_q, dz_d;

   logic               is_signed;
   logic [WIDTH-1:0]   a_mag, b_mag;
   logic [WIDTH:0]     mul_sum, rem_sh, rem_diff;
   logic [2*WIDTH-1:0] mul_next, div_next, prod;

   assign is_signed = op[0];
   assign a_mag = (is_signed && operand_a[WIDTH-1]) ? -operand_a : operand_a;
   assign b_mag = (is_signed && operand_b[WIDTH-1]) ? -operand_b : operand_b;

   // Shift-add step; the carry out of the upper-half add shifts back in at the top.
   assign mul_sum  = acc_q[0] ? ({1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, b_q})
                              : {1'b0, acc_q[2*WIDTH-1:WIDTH]};
   assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

   // Restoring-divide step; bit WIDTH of the difference is the borrow.
   assign rem_sh   = acc_q[2*WIDTH-1:WIDTH-1];
   assign rem_diff = rem_sh - {1'b0, b_q};
   assign div_next = rem_diff[WIDTH] ? {rem_sh[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b0}
                                     : {rem_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};

   assign prod = sgn_quo_q ? -acc_q : acc_q;

   always_comb begin
      state_d   = state_q;
      count_d   = count_q;
      acc_d     = acc_q;
      b_d       = b_q;
      is_div_d  = is_div_q;
      sgn_quo_d = sgn_quo_q;
      sgn_rem_d = sgn_rem_q;
      hi_d      = hi_q;
      lo_d      = lo_q;
      done_d    = 1'b0;
      dz_d      = dz_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (!flush) begin
                  b_d       = b_mag;
                  acc_d     = {{WIDTH{1'b0}}, a_mag};
                  count_d   = '0;
                  is_div_d  = op[1];
                  sgn_quo_d = is_signed & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
                  sgn_rem_d = is_signed & operand_a[WIDTH-1];
                  dz_d      = op[1] && (operand_b == '0);
                  state_d   = dz_d ? StFix : StRun;
               end
            end else begin
               if (hi_we) hi_d = wdata;
               if (lo_we) lo_d = wdata;
            end
         end
         StRun: begin
            if (flush) begin
               state_d = StIdle;
               count_d = '0;
               dz_d    = 1'b0;
            end else begin
               acc_d   = is_div_q ? div_next : mul_next;
               count_d = count_q + 1'b1;
               if (count_q == CW'(WIDTH - 1)) state_d = StFix;
            end
         end
         StFix: begin
            state_d = StIdle;
            count_d = '0;
            if (flush) begin
               dz_d = 1'b0;
            end else begin
               done_d = 1'b1;
               if (!is_div_q) begin
                  {hi_d, lo_d} = prod;
               end else if (dz_q) begin
                  // acc still holds |a|; re-apply the sign to return a as presented.
                  hi_d = sgn_rem_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  lo_d = '1;
               end else begin
                  lo_d = sgn_quo_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
                  hi_d = sgn_rem_q ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         count_q   <= '0;
         acc_q     <= '0;
         b_q       <= '0;
         is_div_q  <= 1'b0;
         sgn_quo_q <= 1'b0;
         sgn_rem_q <= 1'b0;
         hi_q      <= '0;
         lo_q      <= '0;
         done_q    <= 1'b0;
         dz_q      <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         acc_q     <= acc_d;
         b_q       <= b_d;
         is_div_q  <= is_div_d;
         sgn_quo_q <= sgn_quo_d;
         sgn_rem_q <= sgn_rem_d;
         hi_q      <= hi_d;
         lo_q      <= lo_d;
         done_q    <= done_d;
         dz_q      <= dz_d;
      end
   end

   assign busy     = (state_q != StIdle);
   assign stall    = busy & (start | hilo_read | hi_we | lo_we);
   assign done     = done_q;
   assign div_zero = dz_q;
   assign hi       = hi_q;
   assign lo       = lo_q;

endmodule

// File: doc/exe_muldiv_ctrl.md
# exe_muldiv_ctrl

Multi-cycle multiply/divide sequencer beside the EXE stage ALU. It accepts MULT/MULTU/DIV/DIVU from EXE using the post-forwarding operands, and iterates a 32-step shift-add / restoring-divide datapath. It owns the HI/LO registers and raises a pipeline stall while a result is pending and a dependent instruction needs it. Operates in parallel with the single-cycle ALU, which stays free for independent instructions.

## Interface
Parameters:
- WIDTH, 32, operand and HI/LO width; iteration count equals WIDTH.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  EXE holds a valid mul/div instruction this cycle
- op  in  2  operation: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- operand_a  in  WIDTH  forwarded rs value (forwarding-mux output, not raw register read)
- operand_b  in  WIDTH  forwarded rt value
- hilo_read  in  1  EXE instruction is MFHI/MFLO
- hi_we  in  1  MTHI write
- lo_we  in  1  MTLO write
- wdata  in  WIDTH  MTHI/MTLO data
- flush  in  1  kill the in-flight operation (branch/exception squash)
- busy  out  1  operation in flight
- stall  out  1  freeze IF/ID/EXE; insert bubble into MEM
- done  out  1  one-cycle pulse: HI/LO just updated by an operation
- div_zero  out  1  sticky until next start: last divide had operand_b == 0
- hi  out  WIDTH  HI register
- lo  out  WIDTH  LO register

## Operation
- States: IDLE, RUN, FIX.
- IDLE, start=1:
  - Latch |a| and |b| for signed ops, or raw values for unsigned ops.
  - Latch sign_q = a[31]^b[31] and sign_r = a[31] for signed ops; both 0 for unsigned ops.
  - Clear count and accumulator. Go to RUN.
- Divide with operand_b == 0: go directly to FIX, set div_zero.
- RUN, multiply: each cycle, if multiplier LSB is 1, add multiplicand into the upper half of the 2·WIDTH accumulator, then shift right one bit.
- RUN, divide: each cycle, shift the remainder:quotient pair left, trial-subtract the divisor, and keep the difference if it is non-negative (quotient bit = 1).
- RUN lasts exactly WIDTH cycles (count 0..WIDTH-1), then goes to FIX.
- FIX is one cycle and writes HI/LO, then goes to IDLE:
  - MULT: negate the 64-bit product if sign_q. HI = product[63:32], LO = product[31:0].
  - DIV: LO = quotient, negated if sign_q. HI = remainder, negated if sign_r. Quotient truncates toward zero.
  - Divide by zero: HI = operand_a as latched, LO = all ones.
  - Overflow case −2^31 / −1: LO = 0x80000000, HI = 0. No flag.
- stall = busy & (start | hilo_read | hi_we | lo_we).
  - Independent instructions proceed while busy.
  - The stalled requester re-presents its signals until busy drops.
- start, hi_we and lo_we are ignored while busy.
- In IDLE, start has priority over hi_we/lo_we; hi_we and lo_we may write together.
- flush:
  - In RUN or FIX: return to IDLE next edge, HI/LO unchanged, no done pulse, div_zero cleared.
  - In IDLE: squashes a same-cycle start.
- Arithmetic uses unsigned WIDTH+1-bit trial subtraction. Products are 2·WIDTH bits; no truncation until the HI/LO split.

## Timing
- Reset (async, rst_n=0): state IDLE, hi=0, lo=0, busy=0, stall=0, done=0, div_zero=0, count=0.
- start sampled in cycle 0:
  - busy=1 in cycles 1..33 (RUN 1..32, FIX 33).
  - HI/LO update on the edge ending cycle 33.
  - done=1 in cycle 34, busy=0 in cycle 34.
  - Total latency 34 cycles.
- Divide by zero: busy=1 in cycle 1 (FIX), HI/LO written at the end of cycle 1, done=1 in cycle 2.
- A new start is accepted in the same cycle done=1, so back-to-back operations run every 34 cycles.
- MFHI/MFLO in cycle 34 reads the new value; the HI/LO output is registered.
- MTHI/MTLO in IDLE updates HI/LO on the next edge; the following cycle sees the new value.
- rst_n asserted mid-RUN: immediate return to the reset values; no done pulse.
- stall and busy are combinational from state and inputs; done and div_zero are registered.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> at cycle 34 hi=0xFFFFFFFE, lo=0x00000001, done pulses once.
- MULT a=−7 (0xFFFFFFF9), b=3 -> hi=0xFFFFFFFF, lo=0xFFFFFFEB. DIV a=−7, b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=100, b=0 -> done at cycle 2, div_zero=1, lo=0xFFFFFFFF, hi=100. DIV 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0.
- Start MULTU at cycle 0, hilo_read=1 at cycle 5 -> stall=1 in cycles 5..33 and 0 in cycle 34. An independent ALU op at cycle 5 with hilo_read=0 -> stall=0.
- flush at cycle 10 of a DIVU -> busy=0 at cycle 11, HI/LO keep prior values, no done. rst_n low at cycle 20 of a MULT -> hi=lo=0, busy=0 immediately.
- MTHI wdata=0x1234 and MTLO wdata=0x5678 together in IDLE -> next cycle hi=0x1234, lo=0x5678. Same attempt while busy -> stall=1, HI/LO unchanged until the operation completes.
